// File: rtl/uart_rx_sniffer.sv
// Passive UART receiver: deserialises frames from a mirrored TX line into a first-word-fall-through byte FIFO.
// Define UART_RX_PARITY_EN to receive 8E1 frames (default build receives 8N1).
module uart_rx_sniffer #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        arst_n,
  input  logic                        rxd,
  output logic [7:0]                  m_data,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        frame_err,
  output logic                        overflow,
  output logic                        parity_err
);
  localparam int CLKS_PER_BIT = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int AW           = $clog2(FIFO_DEPTH);
  localparam int LW           = AW + 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [LW-1:0]    LVL_FULL = LW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_t;

  // Synchroniser plus settle counter: edge detection stays disabled until the
  // previous-sample flop holds a real line value, so a line low at reset
  // release is never mistaken for a start bit.
  logic       rxd_meta_q, rxd_s_q, rxd_prev_q;
  logic [1:0] settle_q;
  logic       fall_edge;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rxd_meta_q <= 1'b1;
      rxd_s_q    <= 1'b1;
      rxd_prev_q <= 1'b1;
      settle_q   <= 2'd0;
    end else begin
      rxd_meta_q <= rxd;
      rxd_s_q    <= rxd_meta_q;
      rxd_prev_q <= rxd_s_q;
      if (settle_q != 2'd3) settle_q <= settle_q + 2'd1;
    end
  end

  assign fall_edge = (settle_q == 2'd3) && rxd_prev_q && !rxd_s_q;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;
  logic             frame_err_q;
  logic             bit_tick;
  logic             push_req;

  assign bit_tick = (cnt_q == CNT_LAST);

`ifdef UART_RX_PARITY_EN
  logic par_bit_q;
  logic parity_err_q;
  logic parity_ok;

  function automatic logic even_par(input logic [7:0] b);
    return ^b;
  endfunction

  assign parity_ok  = (even_par(shift_q) == par_bit_q);
  assign push_req   = (state_q == S_STOP) && bit_tick && rxd_s_q && parity_ok;
  assign parity_err = parity_err_q;
`else
  assign push_req   = (state_q == S_STOP) && bit_tick && rxd_s_q;
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      cnt_q <= cnt_q + CNT_W'(1);
      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (fall_edge) state_q <= S_START;
        end
        S_START: begin
          if (cnt_q == CNT_HALF) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            state_q   <= rxd_s_q ? S_IDLE : S_DATA;
          end
        end
        S_DATA: begin
          if (bit_tick) begin
            cnt_q     <= '0;
            shift_q   <= {rxd_s_q, shift_q[7:1]};
            bit_idx_q <= bit_idx_q + 3'd1;
`ifdef UART_RX_PARITY_EN
            if (bit_idx_q == 3'd7) state_q <= S_PARITY;
`else
            if (bit_idx_q == 3'd7) state_q <= S_STOP;
`endif
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (bit_tick) begin
            cnt_q     <= '0;
            par_bit_q <= rxd_s_q;
            state_q   <= S_STOP;
          end
        end
`endif
        S_STOP: begin
          if (bit_tick) begin
            cnt_q <= '0;
            if (rxd_s_q) begin
              state_q <= S_IDLE;
`ifdef UART_RX_PARITY_EN
              parity_err_q <= !parity_ok;
`endif
            end else begin
              state_q     <= S_BREAK;
              frame_err_q <= 1'b1;
            end
          end
        end
        S_BREAK: begin
          cnt_q <= '0;
          if (rxd_s_q) state_q <= S_IDLE;
        end
        default: begin
          cnt_q   <= '0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Byte FIFO; the head is held in its own register so m_data keeps the last
  // popped byte once the FIFO drains.
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q, wr_d, rd_d;
  logic [LW-1:0] level_q, level_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, overflow_q;
  logic          pop, full, push_ok;

  assign pop     = valid_q && m_ready;
  assign full    = (level_q == LVL_FULL);
  assign push_ok = push_req && (!full || pop);

  always_comb begin
    rd_d    = rd_q + AW'(pop);
    wr_d    = wr_q + AW'(push_ok);
    level_d = level_q + LW'(push_ok) - LW'(pop);
    data_d  = data_q;
    if (level_d != '0) begin
      if (push_ok && (wr_q == rd_d)) data_d = shift_q;
      else                           data_d = mem_q[rd_d];
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      level_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) mem_q[wr_q] <= shift_q;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      level_q    <= level_d;
      data_q     <= data_d;
      valid_q    <= (level_d != '0);
      overflow_q <= push_req && full && !pop;
    end
  end

  assign m_data     = data_q;
  assign m_valid    = valid_q;
  assign fifo_level = level_q;
  assign frame_err  = frame_err_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_uart_rx_sniffer.sv
// Bench for uart_rx_sniffer at 10 clocks per bit: vector table, directed corner sequences
// and randomized frame bursts checked against a queue-based model of the byte stream.
module tb_uart_rx_sniffer;
  localparam int CLK_HZ = 1_000_000;
  localparam int BAUD   = 100_000;
  localparam int DEPTH  = 8;
  localparam int CPB    = 10;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS  = 11;
`else
  localparam int NBITS  = 10;
`endif
  // Clocks from driving the start bit to m_valid being visible:
  // 2 synchroniser flops + 1 edge-detect + half bit + full bits up to the stop sample + 1 register.
  localparam int RISE_LAT = CPB * (NBITS - 1) + 8;
  localparam int STOP_CYC = RISE_LAT - 1;

  logic       clk = 1'b0;
  logic       arst_n;
  logic       rxd;
  logic       m_ready;
  logic [7:0] m_data;
  logic       m_valid;
  logic [3:0] fifo_level;
  logic       frame_err, overflow, parity_err;

  uart_rx_sniffer #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .arst_n(arst_n), .rxd(rxd),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .fifo_level(fifo_level), .frame_err(frame_err), .overflow(overflow),
    .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observer: logs accepted bytes and counts error pulses on the falling edge.
  logic [7:0] popped[$];
  int n_ferr = 0, n_ovf = 0, n_perr = 0, rise_cyc = -1;
  logic vprev = 1'b0;
  always @(negedge clk) begin
    if (m_valid && m_ready) popped.push_back(m_data);
    if (frame_err)  n_ferr++;
    if (overflow)   n_ovf++;
    if (parity_err) n_perr++;
    if (m_valid && !vprev) rise_cyc = cyc;
    vprev = m_valid;
  end

  int n_pass = 0, n_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) tick();
  endtask

  // Drives one frame; m_ready pulses on cycle pop_at, arst_n pulses on cycle rst_at.
  task automatic send_frame(input logic [7:0] d, input bit stop, input bit bad_par,
                            input int pop_at, input int rst_at);
    logic b[NBITS];
    b[0] = 1'b0;
    for (int i = 0; i < 8; i++) b[i+1] = d[i];
    if (NBITS == 11) b[9] = (^d) ^ bad_par;
    b[NBITS-1] = stop;
    for (int c = 0; c < NBITS * CPB; c++) begin
      rxd     = b[c / CPB];
      m_ready = (c == pop_at);
      if (c == rst_at) begin
        arst_n = 1'b0;
        #2;
        check("rst_mid_valid", int'(m_valid), 0);
        check("rst_mid_level", int'(fifo_level), 0);
        #1;
        arst_n = 1'b1;
      end
      tick();
    end
    m_ready = 1'b0;
  endtask

  task automatic drain(input bit rnd);
    for (int i = 0; i < 300 && m_valid; i++) begin
      m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
    end
    m_ready = 1'b0;
    tick();
    check("drain_empty", int'(m_valid), 0);
  endtask

  typedef struct {
    logic [7:0] data;
    bit         stop;
    bit         bad_par;
    int         exp_level;
    int         exp_ferr;
    int         exp_perr;
  } vec_t;
  vec_t vecs[$];

  int bf, bo, bp, pb, c0, n, kind;
  logic [7:0] last_good, d;
  bit stopb, badp;
  logic [7:0] exp_q[$];
  int e_f, e_o, e_p;

  task automatic snap();
    bf = n_ferr; bo = n_ovf; bp = n_perr; pb = popped.size();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs.push_back(vec_t'{8'h5A, 1'b1, 1'b0, 1, 0, 0});
    vecs.push_back(vec_t'{8'h00, 1'b1, 1'b0, 1, 0, 0});
    vecs.push_back(vec_t'{8'hC3, 1'b0, 1'b0, 0, 1, 0});
    vecs.push_back(vec_t'{8'hFF, 1'b1, 1'b0, 1, 0, 0});
    vecs.push_back(vec_t'{8'h81, 1'b0, 1'b0, 0, 1, 0});
    vecs.push_back(vec_t'{8'h7F, 1'b1, 1'b0, 1, 0, 0});
`ifdef UART_RX_PARITY_EN
    vecs.push_back(vec_t'{8'h03, 1'b1, 1'b0, 1, 0, 0});
    vecs.push_back(vec_t'{8'h03, 1'b1, 1'b1, 0, 0, 1});
    vecs.push_back(vec_t'{8'h03, 1'b0, 1'b1, 0, 1, 0});
`endif

    rxd = 1'b1; m_ready = 1'b0; arst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_valid", int'(m_valid), 0);
    check("reset_level", int'(fifo_level), 0);
    check("reset_data", int'(m_data), 0);
    check("reset_ferr", int'(frame_err), 0);
    check("reset_ovf", int'(overflow), 0);
    check("reset_perr", int'(parity_err), 0);
    arst_n = 1'b1;
    idle(10);

    // Single byte and its exact m_valid latency
    snap();
    c0 = cyc;
    send_frame(8'hA5, 1'b1, 1'b0, -1, -1);
    idle(5);
    check("a5_rise_latency", rise_cyc - c0, RISE_LAT);
    check("a5_level", int'(fifo_level), 1);
    check("a5_data", int'(m_data), 8'hA5);
    check("a5_ferr", n_ferr - bf, 0);
    check("a5_ovf", n_ovf - bo, 0);
    check("a5_perr", n_perr - bp, 0);
    drain(1'b0);

    // Back-to-back frames, then ordered pops
    send_frame(8'h00, 1'b1, 1'b0, -1, -1);
    send_frame(8'hFF, 1'b1, 1'b0, -1, -1);
    send_frame(8'h3C, 1'b1, 1'b0, -1, -1);
    idle(5);
    check("b2b_level", int'(fifo_level), 3);
    snap();
    drain(1'b0);
    check("b2b_pops", popped.size() - pb, 3);
    if (popped.size() - pb == 3) begin
      check("b2b_pop0", int'(popped[pb]), 8'h00);
      check("b2b_pop1", int'(popped[pb+1]), 8'hFF);
      check("b2b_pop2", int'(popped[pb+2]), 8'h3C);
    end

    // Vector table
    last_good = 8'h3C;
    foreach (vecs[i]) begin
      snap();
      send_frame(vecs[i].data, vecs[i].stop, vecs[i].bad_par, -1, -1);
      idle(20);
      check("vec_level", int'(fifo_level), vecs[i].exp_level);
      if (vecs[i].exp_level != 0) last_good = vecs[i].data;
      check("vec_data", int'(m_data), int'(last_good));
      check("vec_ferr", n_ferr - bf, vecs[i].exp_ferr);
      check("vec_perr", n_perr - bp, vecs[i].exp_perr);
      check("vec_ovf", n_ovf - bo, 0);
      drain(1'b0);
    end

    // Overflow: nine bytes into an eight-deep FIFO
    snap();
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b1, 1'b0, -1, -1);
    idle(5);
    check("ovf_level", int'(fifo_level), DEPTH);
    check("ovf_pulses", n_ovf - bo, 1);
    drain(1'b0);
    check("ovf_pops", popped.size() - pb, DEPTH);
    for (int j = 0; j < DEPTH; j++)
      if (pb + j < popped.size()) check("ovf_order", int'(popped[pb+j]), j + 1);

    // Full FIFO with a pop coinciding with the ninth stop sample
    snap();
    for (int i = 1; i <= 8; i++) send_frame(8'(i), 1'b1, 1'b0, -1, -1);
    send_frame(8'h09, 1'b1, 1'b0, STOP_CYC, -1);
    idle(5);
    check("popfull_ovf", n_ovf - bo, 0);
    check("popfull_level", int'(fifo_level), DEPTH);
    check("popfull_popcnt", popped.size() - pb, 1);
    if (popped.size() > pb) check("popfull_first", int'(popped[pb]), 1);
    snap();
    drain(1'b0);
    check("popfull_drain", popped.size() - pb, DEPTH);
    for (int j = 0; j < DEPTH; j++)
      if (pb + j < popped.size()) check("popfull_order", int'(popped[pb+j]), j + 2);

    // Short low glitch
    snap();
    rxd = 1'b0;
    repeat (3) tick();
    idle(40);
    check("glitch_level", int'(fifo_level), 0);
    check("glitch_ferr", n_ferr - bf, 0);

    // Stop bit low, line held low, then a clean frame
    snap();
    send_frame(8'h96, 1'b0, 1'b0, -1, -1);
    repeat (50) tick();
    idle(10);
    check("break_ferr", n_ferr - bf, 1);
    check("break_level", int'(fifo_level), 0);
    send_frame(8'h55, 1'b1, 1'b0, -1, -1);
    idle(5);
    check("after_break_level", int'(fifo_level), 1);
    check("after_break_data", int'(m_data), 8'h55);
    drain(1'b0);

    // Reset during data bit 4 with two bytes buffered
    send_frame(8'h11, 1'b1, 1'b0, -1, -1);
    send_frame(8'h22, 1'b1, 1'b0, -1, -1);
    idle(3);
    check("prerst_level", int'(fifo_level), 2);
    send_frame(8'hE5, 1'b1, 1'b0, -1, 5 * CPB + 2);
    idle(15);
    check("postrst_level", int'(fifo_level), 0);
    check("postrst_valid", int'(m_valid), 0);
    send_frame(8'h7E, 1'b1, 1'b0, -1, -1);
    idle(5);
    check("postrst_7e_level", int'(fifo_level), 1);
    check("postrst_7e_data", int'(m_data), 8'h7E);
    drain(1'b0);

    // Randomized bursts against the queue model
    for (int r = 0; r < 6; r++) begin
      exp_q.delete();
      e_f = 0; e_o = 0; e_p = 0;
      snap();
      n = $urandom_range(1, 11);
      for (int k = 0; k < n; k++) begin
        d     = 8'($urandom);
        kind  = $urandom_range(0, 7);
        stopb = (kind != 0);
        badp  = (NBITS == 11) && (kind == 1);
        send_frame(d, stopb, badp, -1, -1);
        if (!stopb) begin
          e_f++;
          repeat ($urandom_range(0, 20)) tick();
          idle(3 + $urandom_range(0, 5));
        end else if (badp) begin
          e_p++;
          idle($urandom_range(0, 6));
        end else begin
          if (exp_q.size() < DEPTH) exp_q.push_back(d);
          else e_o++;
          idle($urandom_range(0, 6));
        end
      end
      idle(5);
      check("rnd_level", int'(fifo_level), exp_q.size());
      check("rnd_ferr", n_ferr - bf, e_f);
      check("rnd_ovf", n_ovf - bo, e_o);
      check("rnd_perr", n_perr - bp, e_p);
      drain(1'b1);
      check("rnd_pops", popped.size() - pb, exp_q.size());
      foreach (exp_q[j])
        if (pb + j < popped.size()) check("rnd_data", int'(popped[pb+j]), int'(exp_q[j]));
    end

`ifndef UART_RX_PARITY_EN
    check("parity_err_never", n_perr, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
